// File: rtl/scroll_checker_gen.sv
// Scrolling checkerboard pattern generator.
// Fixed-point offsets advance once per qualified frame. A palette index steps
// every PALETTE_PERIOD qualified frames. The colour output is one register
// stage behind the pixel coordinates.
module scroll_checker_gen #(
  parameter int TILE_LOG2      = 5,
  parameter int FRAC_BITS      = 4,
  parameter int PALETTE_PERIOD = 60
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pattern_enable,
  input  logic [9:0]             x,
  input  logic [9:0]             y,
  input  logic                   active,
  input  logic                   next_frame,
  input  logic [8+FRAC_BITS-1:0] step_size,
  input  logic [1:0]             dir,
  output logic [5:0]             rgb
);

  localparam int         AW       = 10 + FRAC_BITS;
  localparam logic [7:0] CNT_LAST = 8'(PALETTE_PERIOD - 1);

  logic [AW-1:0] x_acc_q, x_acc_d, y_acc_q, y_acc_d, step_ext;
  logic [7:0]    frame_cnt_q, frame_cnt_d;
  logic [1:0]    pal_idx_q, pal_idx_d;
  logic [5:0]    rgb_q, rgb_d;
  logic [9:0]    sx, sy;
  logic [5:0]    fg, bg;
  logic          qual, tile_sel;
  logic          unused_sxy;

  assign qual     = pattern_enable & next_frame;
  assign step_ext = AW'(step_size);

  // Offset accumulators: wrap freely, fractional carry lands on the same edge.
  always_comb begin
    x_acc_d = x_acc_q;
    y_acc_d = y_acc_q;
    if (qual) begin
      case (dir)
        2'b00:   x_acc_d = x_acc_q + step_ext;
        2'b01:   x_acc_d = x_acc_q - step_ext;
        2'b10:   y_acc_d = y_acc_q + step_ext;
        default: begin
          x_acc_d = x_acc_q + step_ext;
          y_acc_d = y_acc_q + step_ext;
        end
      endcase
    end
  end

  // Frame counter and palette index; the palette steps as the counter wraps.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    pal_idx_d   = pal_idx_q;
    if (qual) begin
      if (frame_cnt_q == CNT_LAST) begin
        frame_cnt_d = '0;
        pal_idx_d   = pal_idx_q + 2'd1;
      end else begin
        frame_cnt_d = frame_cnt_q + 8'd1;
      end
    end
  end

  // Pixel colour from pre-edge offsets and palette; runs even when disabled.
  always_comb begin
    sx       = x + x_acc_q[AW-1 -: 10];
    sy       = y + y_acc_q[AW-1 -: 10];
    tile_sel = sx[TILE_LOG2] ^ sy[TILE_LOG2];
    case (pal_idx_q)
      2'd0:    begin fg = 6'b100100; bg = 6'b000000; end
      2'd1:    begin fg = 6'b001001; bg = 6'b000000; end
      2'd2:    begin fg = 6'b010010; bg = 6'b000000; end
      default: begin fg = 6'b111111; bg = 6'b010101; end
    endcase
    rgb_d = active ? (tile_sel ? fg : bg) : 6'b000000;
  end

  // Only the tile bit of the scrolled coordinates is consumed.
  assign unused_sxy = ^{sx[9:TILE_LOG2+1], sx[TILE_LOG2-1:0],
                        sy[9:TILE_LOG2+1], sy[TILE_LOG2-1:0]};

  // State registers, all cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_acc_q     <= '0;
      y_acc_q     <= '0;
      frame_cnt_q <= '0;
      pal_idx_q   <= '0;
      rgb_q       <= '0;
    end else begin
      x_acc_q     <= x_acc_d;
      y_acc_q     <= y_acc_d;
      frame_cnt_q <= frame_cnt_d;
      pal_idx_q   <= pal_idx_d;
      rgb_q       <= rgb_d;
    end
  end

  assign rgb = rgb_q;

endmodule

// File: tb/tb_scroll_checker_gen.sv
// Bench for scroll_checker_gen: a constant vector table, hand-written corner
// sequences and randomized traffic, all compared against an arithmetic model.
module tb_scroll_checker_gen;

  localparam int TILE  = 32;
  localparam int FRAC  = 4;
  localparam int ACC_M = 1 << (10 + FRAC);
  localparam int PER   = 60;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pattern_enable = 1'b0;
  logic [9:0]  x = '0, y = '0;
  logic        active = 1'b0;
  logic        next_frame = 1'b0;
  logic [11:0] step_size = '0;
  logic [1:0]  dir = '0;
  logic [5:0]  rgb;

  scroll_checker_gen dut (
    .clk(clk), .rst_n(rst_n), .pattern_enable(pattern_enable),
    .x(x), .y(y), .active(active), .next_frame(next_frame),
    .step_size(step_size), .dir(dir), .rgb(rgb)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  int m_xa, m_ya, m_fc, m_pal;
  logic [5:0] fg_tab [4] = '{6'b100100, 6'b001001, 6'b010010, 6'b111111};
  logic [5:0] bg_tab [4] = '{6'b000000, 6'b000000, 6'b000000, 6'b010101};

  typedef struct {
    int         xi;
    int         yi;
    bit         act;
    logic [5:0] exp;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] model_rgb(input int xi, input int yi, input bit ac);
    int sx, sy;
    sx = (xi + m_xa / (1 << FRAC)) % 1024;
    sy = (yi + m_ya / (1 << FRAC)) % 1024;
    if (!ac) return 6'b0;
    return (((sx / TILE) + (sy / TILE)) % 2 == 1) ? fg_tab[m_pal] : bg_tab[m_pal];
  endfunction

  function automatic int x_off();
    return int'(dut.x_acc_q) >> FRAC;
  endfunction

  function automatic int y_off();
    return int'(dut.y_acc_q) >> FRAC;
  endfunction

  // One clock: drive, predict from pre-edge model state, advance, compare.
  task automatic tick(input bit pe, input bit nf, input int st, input int d,
                      input int xi, input int yi, input bit ac);
    logic [5:0] e;
    pattern_enable = pe; next_frame = nf; step_size = 12'(st); dir = 2'(d);
    x = 10'(xi); y = 10'(yi); active = ac;
    e = model_rgb(xi, yi, ac);
    @(posedge clk);
    if (pe && nf) begin
      if (d == 0 || d == 3) m_xa = (m_xa + st) % ACC_M;
      if (d == 1)           m_xa = (m_xa - st + ACC_M) % ACC_M;
      if (d == 2 || d == 3) m_ya = (m_ya + st) % ACC_M;
      m_fc = m_fc + 1;
      if (m_fc == PER) begin
        m_fc  = 0;
        m_pal = (m_pal + 1) % 4;
      end
    end
    #1;
    chk("rgb", int'(rgb), int'(e));
    chk("x_acc", int'(dut.x_acc_q), m_xa);
    chk("y_acc", int'(dut.y_acc_q), m_ya);
    chk("pal_idx", int'(dut.pal_idx_q), m_pal);
  endtask

  task automatic do_reset();
    pattern_enable = 0; next_frame = 0; active = 0;
    rst_n = 1'b0;
    #2;
    chk("rst_rgb", int'(rgb), 0);
    chk("rst_x_acc", int'(dut.x_acc_q), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_xa = 0; m_ya = 0; m_fc = 0; m_pal = 0;
  endtask

  initial begin
    tbl[0] = '{0,    0,  1'b1, 6'b000000};
    tbl[1] = '{32,   0,  1'b1, 6'b100100};
    tbl[2] = '{32,   32, 1'b1, 6'b000000};
    tbl[3] = '{0,    32, 1'b1, 6'b100100};
    tbl[4] = '{32,   0,  1'b0, 6'b000000};
    tbl[5] = '{1023, 0,  1'b1, 6'b100100};
    tbl[6] = '{63,   0,  1'b1, 6'b100100};
    tbl[7] = '{64,   0,  1'b1, 6'b000000};

    // Reset state and static checkerboard at zero offset.
    #3;
    do_reset();
    foreach (tbl[i]) begin
      tick(0, 0, 0, 0, tbl[i].xi, tbl[i].yi, tbl[i].act);
      chk($sformatf("tbl%0d", i), int'(rgb), int'(tbl[i].exp));
    end

    // Integer scroll right by 3, then disabled frames hold the offset.
    do_reset();
    repeat (3) tick(1, 1, 16, 0, 0, 0, 0);
    chk("x_off_3", x_off(), 3);
    tick(0, 0, 0, 0, 29, 0, 1);
    chk("rgb_x29", int'(rgb), 6'b100100);
    repeat (3) tick(0, 1, 16, 0, 0, 0, 0);
    chk("x_off_hold", x_off(), 3);

    // Half-pixel step carries into the integer part on the second frame.
    do_reset();
    tick(1, 1, 8, 0, 0, 0, 0);
    chk("x_off_half1", x_off(), 0);
    tick(1, 1, 8, 0, 0, 0, 0);
    chk("x_off_half2", x_off(), 1);

    // Left wrap on the very first edge after reset, then diagonal.
    do_reset();
    tick(1, 1, 16, 1, 0, 0, 0);
    chk("x_off_wrap", x_off(), 1023);
    tick(1, 1, 16, 3, 0, 0, 0);
    chk("x_off_diag", x_off(), 0);
    chk("y_off_diag", y_off(), 1);

    // Palette cycling with zero step.
    do_reset();
    repeat (60) tick(1, 1, 0, 0, 0, 0, 0);
    chk("pal_60", int'(dut.pal_idx_q), 1);
    chk("x_off_step0", x_off(), 0);
    tick(0, 0, 0, 0, 32, 0, 1);
    chk("fg_pal1", int'(rgb), 6'b001001);
    repeat (120) tick(1, 1, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0, 1);
    chk("bg_pal3", int'(rgb), 6'b010101);
    repeat (60) tick(1, 1, 0, 0, 0, 0, 0);
    chk("pal_240", int'(dut.pal_idx_q), 0);

    // Asynchronous reset in the middle of a scroll.
    do_reset();
    tick(1, 1, 80, 0, 0, 0, 0);
    repeat (119) tick(1, 1, 0, 0, 0, 0, 0);
    chk("pre_x_off", x_off(), 5);
    chk("pre_pal", int'(dut.pal_idx_q), 2);
    tick(0, 0, 0, 0, 27, 0, 1);
    chk("pre_rgb", int'(rgb), 6'b010010);
    rst_n = 1'b0;
    #1;
    chk("async_rgb", int'(rgb), 0);
    chk("async_x_acc", int'(dut.x_acc_q), 0);
    chk("async_pal", int'(dut.pal_idx_q), 0);
    chk("async_fcnt", int'(dut.frame_cnt_q), 0);
    m_xa = 0; m_ya = 0; m_fc = 0; m_pal = 0;
    #2;
    rst_n = 1'b1;

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      tick($urandom_range(7, 0) != 0, $urandom_range(2, 0) == 0,
           int'($urandom_range(4095, 0)), int'($urandom_range(3, 0)),
           int'($urandom_range(1023, 0)), int'($urandom_range(1023, 0)),
           $urandom_range(3, 0) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
